// File: rtl/memoria_arb_pkg.sv
// Shared types and defaults for the two-port on-chip memory arbiter.
package memoria_arb_pkg;

  localparam int DEPTH_DEF = 12500;
  localparam int AW_DEF    = 14;
  localparam int DW_DEF    = 32;

  typedef enum logic {
    P_CPU = 1'b0,
    P_DMA = 1'b1
  } port_t;

  // Tag travelling one cycle behind an accepted read
  typedef struct packed {
    logic  vld;
    port_t own;
    logic  zero;
  } rd_tag_t;

endpackage

// File: rtl/memoria_rr_grant.sv
// Two-way grant selection for memoria_arbiter.
// Build option: MEMORIA_ARB_FIXED_PRIO_EN makes port 1 (DMA) win every
// contention; otherwise contention alternates away from the last grantee.
module memoria_rr_grant
  import memoria_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last,
  output logic [1:0] grant
);

`ifdef MEMORIA_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  // One-hot grant: a lone requester always wins, contention is resolved here
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
`ifdef MEMORIA_ARB_FIXED_PRIO_EN
      grant = 2'b10;
`else
      grant = (last == P_CPU) ? 2'b10 : 2'b01;
`endif
    end
  end

endmodule

// File: rtl/memoria_arbiter.sv
// Arbiter sharing the single-port on-chip RAM between the Nios data master
// (port 0) and the capture DMA (port 1). One access per cycle, reads return
// one cycle later, out-of-range accesses are accepted but never reach the RAM.
// Build option: MEMORIA_ARB_FIXED_PRIO_EN (see memoria_rr_grant).
module memoria_arbiter
  import memoria_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [AW-1:0]     m0_address,
  input  logic [DW/8-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DW-1:0]     m0_writedata,
  output logic              m0_waitrequest,
  output logic [DW-1:0]     m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [AW-1:0]     m1_address,
  input  logic [DW/8-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DW-1:0]     m1_writedata,
  output logic              m1_waitrequest,
  output logic [DW-1:0]     m1_readdata,
  output logic              m1_readdatavalid,

  output logic [AW-1:0]     mem_address,
  output logic [DW/8-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DW-1:0]     mem_writedata,
  input  logic [DW-1:0]     mem_readdata,

  output logic [1:0]        oor_err,
  input  logic              err_clr
);

  // One extra bit so DEPTH == 2**AW still compares correctly
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic [1:0]      req;
  logic [1:0]      grant;
  logic            any_grant;
  port_t           sel;
  port_t           last;
  logic [AW-1:0]   sel_addr;
  logic [DW/8-1:0] sel_be;
  logic [DW-1:0]   sel_wd;
  logic            sel_rd;
  logic            sel_wr;
  logic            in_range;
  logic [1:0]      oor_set;
  logic [DW-1:0]   ret_data;
  rd_tag_t         rd_tag_p1;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  memoria_rr_grant u_grant (
    .req   (req),
    .last  (last),
    .grant (grant)
  );

  assign any_grant = |grant;
  assign sel       = grant[1] ? P_DMA : P_CPU;

  // Mux the granted master's command onto the RAM port
  always_comb begin
    sel_addr = m0_address;
    sel_be   = m0_byteenable;
    sel_wd   = m0_writedata;
    sel_rd   = m0_read;
    sel_wr   = m0_write;
    if (sel == P_DMA) begin
      sel_addr = m1_address;
      sel_be   = m1_byteenable;
      sel_wd   = m1_writedata;
      sel_rd   = m1_read;
      sel_wr   = m1_write;
    end
  end

  assign in_range       = ({1'b0, sel_addr} < DEPTH_LIM);
  assign mem_address    = sel_addr;
  assign mem_byteenable = sel_be;
  assign mem_writedata  = sel_wd;
  assign mem_chipselect = any_grant & in_range;
  assign mem_write      = any_grant & sel_wr & in_range;

  assign m0_waitrequest = req[0] & ~grant[0];
  assign m1_waitrequest = req[1] & ~grant[1];
  assign oor_set        = grant & {2{~in_range}};

  // Remember the last grantee so contention alternates
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          last <= P_CPU;
    else if (any_grant) last <= sel;
  end

  // Sticky out-of-range flags; a clear beats a same-cycle set
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        oor_err <= '0;
    else if (err_clr) oor_err <= '0;
    else              oor_err <= oor_err | oor_set;
  end

  // ---- stage p0 -> p1: capture who owns the read returning next cycle ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_tag_p1 <= '0;
    end else begin
      rd_tag_p1.vld  <= any_grant & sel_rd;
      rd_tag_p1.own  <= sel;
      rd_tag_p1.zero <= ~in_range;
    end
  end

  // Steer RAM output to the owning port; out-of-range reads return zero
  always_comb begin
    ret_data         = rd_tag_p1.zero ? '0 : mem_readdata;
    m0_readdatavalid = rd_tag_p1.vld & (rd_tag_p1.own == P_CPU);
    m1_readdatavalid = rd_tag_p1.vld & (rd_tag_p1.own == P_DMA);
    m0_readdata      = m0_readdatavalid ? ret_data : '0;
    m1_readdata      = m1_readdatavalid ? ret_data : '0;
  end

endmodule

// File: tb/tb_memoria_arbiter.sv
// Directed bench for memoria_arbiter with a behavioural RAM and a read-return
// scoreboard checked by an independent monitor.
module tb_memoria_arbiter;
  import memoria_arb_pkg::*;

  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [AW-1:0] m0_address, m1_address;
  logic [3:0]    m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_q = '0;
  logic [1:0]    oor_err;
  logic          err_clr;

  memoria_arbiter #(.DEPTH(12500), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_q),
    .oor_err(oor_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, output registered by the address edge
  logic [31:0] ram [0:12499];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_q <= ram[mem_address];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic expect_rd(input int port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: every returned read is matched against the scoreboard
  always @(negedge clk) begin
    if (m0_readdatavalid || m1_readdatavalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rdv", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("rdv_owner", {30'b0, m1_readdatavalid, m0_readdatavalid},
            (mon_e.port == 1) ? 32'h2 : 32'h1);
        chk("rd_data", (mon_e.port == 1) ? m1_readdata : m0_readdata, mon_e.data);
        chk("rd_other_zero", (mon_e.port == 1) ? m0_readdata : m1_readdata, 32'h0);
        chk("rd_latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic set_port(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic idle();
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0, '0);
    err_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    idle();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_m0_wait", m0_waitrequest, 0);
    chk("rst_m1_wait", m1_waitrequest, 0);
    chk("rst_m0_rdv", m0_readdatavalid, 0);
    chk("rst_m1_rdv", m1_readdatavalid, 0);
    chk("rst_m0_rdata", m0_readdata, 0);
    chk("rst_m1_rdata", m1_readdata, 0);
    chk("rst_oor", oor_err, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_wr", mem_write, 0);
    tick();
    reset = 1'b0;

    // m0 write then read back the same word
    set_port(0, 1'b0, 1'b1, 14'h0010, 4'hF, 32'hCAFEBABE);
    settle();
    chk("wr0_wait", m0_waitrequest, 0);
    chk("wr0_cs", mem_chipselect, 1);
    chk("wr0_memwr", mem_write, 1);
    chk("wr0_addr", mem_address, 32'h10);
    tick();
    set_port(0, 1'b1, 1'b0, 14'h0010, 4'h0, 32'h0);
    expect_rd(0, 32'hCAFEBABE);
    settle();
    chk("rd0_wait", m0_waitrequest, 0);
    chk("rd0_memwr", mem_write, 0);
    tick();

    // m1 writes while m0's read returns; then a byte-lane merge
    idle();
    set_port(1, 1'b0, 1'b1, 14'h0020, 4'hF, 32'hFFFFFFFF);
    settle();
    chk("wr1_wait", m1_waitrequest, 0);
    chk("wr1_memwr", mem_write, 1);
    tick();
    set_port(1, 1'b0, 1'b1, 14'h0020, 4'b0101, 32'h11223344);
    settle();
    chk("wr1_be", mem_byteenable, 32'h5);
    tick();
    set_port(1, 1'b1, 1'b0, 14'h0020, 4'h0, 32'h0);
    expect_rd(1, 32'hFF22FF44);
    tick();

    // Single m0 read leaves last = port 0 before contention
    idle();
    set_port(0, 1'b1, 1'b0, 14'h0010, 4'h0, 32'h0);
    expect_rd(0, 32'hCAFEBABE);
    tick();

    // Both ports read every cycle
    for (int k = 0; k < 6; k++) begin
      set_port(0, 1'b1, 1'b0, 14'h0010, 4'h0, 32'h0);
      set_port(1, 1'b1, 1'b0, 14'h0020, 4'h0, 32'h0);
`ifdef MEMORIA_ARB_FIXED_PRIO_EN
      w = 1;
`else
      w = (k % 2 == 0) ? 1 : 0;
`endif
      expect_rd(w, (w == 1) ? 32'hFF22FF44 : 32'hCAFEBABE);
      settle();
      chk("cont_m0_wait", m0_waitrequest, (w == 1) ? 1 : 0);
      chk("cont_m1_wait", m1_waitrequest, (w == 0) ? 1 : 0);
      tick();
    end

    // Out-of-range write from m0
    idle();
    set_port(0, 1'b0, 1'b1, 14'd12500, 4'hF, 32'hDEADBEEF);
    settle();
    chk("oorw_wait", m0_waitrequest, 0);
    chk("oorw_cs", mem_chipselect, 0);
    chk("oorw_memwr", mem_write, 0);
    tick();
    idle();
    settle();
    chk("oorw_flag", oor_err, 32'h1);
    tick();

    // Out-of-range read returns zero even though the RAM output is not zero
    set_port(0, 1'b1, 1'b0, 14'd13000, 4'h0, 32'h0);
    expect_rd(0, 32'h0);
    settle();
    chk("oorr_wait", m0_waitrequest, 0);
    chk("oorr_cs", mem_chipselect, 0);
    tick();

    // Clear, then clear coinciding with a new out-of-range access
    idle();
    err_clr = 1'b1;
    tick();
    set_port(1, 1'b1, 1'b0, 14'd13000, 4'h0, 32'h0);
    expect_rd(1, 32'h0);
    settle();
    chk("clr_flag", oor_err, 32'h0);
    tick();
    idle();
    settle();
    chk("clr_wins", oor_err, 32'h0);
    tick();

    // m1 out-of-range write sets bit 1
    set_port(1, 1'b0, 1'b1, 14'd16000, 4'hF, 32'h12345678);
    tick();
    // Read accepted, then reset in the following cycle
    set_port(1, 1'b1, 1'b0, 14'h0020, 4'h0, 32'h0);
    settle();
    chk("oor1_flag", oor_err, 32'h2);
    chk("pre_rst_wait", m1_waitrequest, 0);
    tick();
    idle();
    reset = 1'b1;
    settle();
    chk("midrst_m0_rdv", m0_readdatavalid, 0);
    chk("midrst_m1_rdv", m1_readdatavalid, 0);
    chk("midrst_m1_rdata", m1_readdata, 0);
    chk("midrst_oor", oor_err, 0);
    chk("midrst_cs", mem_chipselect, 0);
    tick();
    reset = 1'b0;

    // Contention right after reset: last = 0, so port 1 wins first
    set_port(0, 1'b1, 1'b0, 14'h0010, 4'h0, 32'h0);
    set_port(1, 1'b1, 1'b0, 14'h0020, 4'h0, 32'h0);
    expect_rd(1, 32'hFF22FF44);
    settle();
    chk("postrst_m0_wait", m0_waitrequest, 1);
    chk("postrst_m1_wait", m1_waitrequest, 0);
    tick();
    set_port(1, 1'b0, 1'b0, '0, '0, '0);
    expect_rd(0, 32'hCAFEBABE);
    settle();
    chk("postrst_m0_go", m0_waitrequest, 0);
    tick();
    idle();
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/memoria_arbiter.md
# memoria_arbiter

Two-requester arbiter for the single-port on-chip memory of `sopc_2`. Shares the 12500×32 RAM between the Nios data master (port 0) and the image-capture DMA (port 1). Issues at most one access per cycle, returns read data with a fixed one-cycle latency and blocks writes outside the populated range. Sits between the two Avalon-MM masters and the memory's `address/byteenable/chipselect/write/writedata/readdata` slave port.

## Interface
- `DEPTH`, 12500: populated words; addresses ≥ DEPTH are out of range.
- `AW`, 14: word-address width.
- `DW`, 32: data width; byte-enable width is DW/8.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `mN_address`  in  AW  word address, N∈{0,1}.
- `mN_byteenable`  in  DW/8  byte lanes for writes.
- `mN_read`, `mN_write`  in  1  request strobes; both high at once is illegal.
- `mN_writedata`  in  DW  write data.
- `mN_waitrequest`  out  1  request not accepted this cycle.
- `mN_readdata`  out  DW  read data.
- `mN_readdatavalid`  out  1  `mN_readdata` valid.
- `mem_address` out AW, `mem_byteenable` out DW/8, `mem_chipselect` out 1, `mem_write` out 1, `mem_writedata` out DW: RAM command.
- `mem_readdata`  in  DW  unregistered RAM output.
- `oor_err`  out  2  sticky out-of-range flag per port; cleared by `err_clr`.
- `err_clr`  in  1  clears both `oor_err` bits.

## Operation
- Request: `mN_read | mN_write`. Grant is combinational each cycle; exactly one requester is granted.
- Default policy: round-robin. `last` register (reset 0) holds the last granted port. On contention, grant `~last`. A single requester is always granted. `last` updates only on a granted cycle.
- Granted port: `mN_waitrequest`=0, and its command is muxed onto `mem_*`. A requesting loser sees `waitrequest`=1 and must hold its signals. `waitrequest`=0 when the port is not requesting.
- `mem_chipselect` = granted & in-range. `mem_write` = granted write & in-range.
- Out-of-range (address ≥ DEPTH), applies to both reads and writes:
  - accepted normally;
  - `mem_chipselect`=0;
  - sets `oor_err[N]`;
  - a read returns 0 with `readdatavalid`.
- Return tracking: registers `rd_vld` (1 bit), `rd_own` (1 bit) and `rd_zero` (1 bit) capture the accepted read. Next cycle: `m<rd_own>_readdatavalid`=1, and `readdata` = `rd_zero ? 0 : mem_readdata`. The other port's readdata is 0.
- `err_clr` has priority over a same-cycle set (cleared result).
- Reset values: all `waitrequest` 0, `readdatavalid` 0, `readdata` 0, `oor_err` 0, `mem_chipselect`/`mem_write` 0 (no requests), `rd_vld` 0, `last` 0.

## Timing
- Accept in cycle N (`req & ~waitrequest`). Write lands at the N→N+1 edge. Read data is valid in cycle N+1, with `readdatavalid` high for exactly one cycle.
- Back-to-back accepts from one port every cycle: full throughput. Under contention each port gets 1/2.
- Read accepted in N, write from the other port in N+1: both proceed. The RAM command path and the return path are independent.
- Same-address write then read (consecutive cycles): the read returns the new data.
- Reset asserted mid-operation: `rd_vld` is cleared immediately and the pending `readdatavalid` is dropped. The master retries after reset.

## Configuration
- `MEMORIA_ARB_FIXED_PRIO_EN` defined: port 1 (DMA) always wins contention and `last` is unused.
- Undefined: round-robin as above.

## Structure
- Package `memoria_arb_pkg`:
  - `DEPTH_DEF=12500`, `AW_DEF=14`, `DW_DEF=32`;
  - `port_t` enum {`P_CPU=0`, `P_DMA=1`};
  - `rd_tag_t` struct {vld, own, zero}.
- One sub-module is natural: `memoria_rr_grant`. Inputs are 2 requests plus `last`; output is the one-hot grant. It contains the `_FIXED_PRIO_EN` switch.

## Test plan
- m0 write 0x0010←0xCAFEBABE (be=1111), then read 0x0010 → `m0_readdatavalid` 1 cycle later with 0xCAFEBABE; `waitrequest` never high.
- m0 and m1 both read every cycle for 6 cycles → grants alternate 1,0,1,0,1,0 (from `last`=0). Each port gets 3 `readdatavalid` with the correct owner. With the macro defined: m1 gets 6 consecutive grants, m0 stalls.
- m1 write 0x0020←0x11223344 with be=0101 over 0xFFFFFFFF → readback 0xFF22FF44.
- m0 write to 12500 → `mem_chipselect` 0, `oor_err`=01, RAM unchanged. m0 read 13000 → returns 0. `err_clr` in the same cycle as a new OOR → `oor_err` stays 0.
- Read accepted, `reset` pulsed in the next cycle → no `readdatavalid`, all outputs at reset values, `last`=0.
